// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared types, constants and the hex key map for the 4x4 keypad contact model.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        HOLD   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [3:0] LINES_IDLE = 4'b1111;

    // col: 0 = C1 .. 3 = C4, row: 0 = R1 .. 3 = R4
    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_rc_t;

    function automatic key_rc_t key_to_rc(input logic [3:0] code);
        key_rc_t rc;
        rc = '0;
        case (code)
            4'h1: rc = '{col: 2'd0, row: 2'd0};
            4'h4: rc = '{col: 2'd0, row: 2'd1};
            4'h7: rc = '{col: 2'd0, row: 2'd2};
            4'h0: rc = '{col: 2'd0, row: 2'd3};
            4'h2: rc = '{col: 2'd1, row: 2'd0};
            4'h5: rc = '{col: 2'd1, row: 2'd1};
            4'h8: rc = '{col: 2'd1, row: 2'd2};
            4'hF: rc = '{col: 2'd1, row: 2'd3};
            4'h3: rc = '{col: 2'd2, row: 2'd0};
            4'h6: rc = '{col: 2'd2, row: 2'd1};
            4'h9: rc = '{col: 2'd2, row: 2'd2};
            4'hE: rc = '{col: 2'd2, row: 2'd3};
            4'hA: rc = '{col: 2'd3, row: 2'd0};
            4'hB: rc = '{col: 2'd3, row: 2'd1};
            4'hC: rc = '{col: 2'd3, row: 2'd2};
            4'hD: rc = '{col: 2'd3, row: 2'd3};
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Key-code handshake between a key source (master) and the keypad emulator (slave).
// A code transfers on the clk edge where key_valid && key_ready; key_code is
// don't-care otherwise, and key_ready never waits on key_valid.
interface keypad_matrix_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_matrix_emulator_row_drive.sv
// Combinational row pattern: pull the key's row low while the contact is closed
// and the scanner strobes the key's column (other strobed columns do not matter).
module keypad_row_drive
    import keypad_pkg::*;
(
    input  logic [1:0] col_idx,
    input  logic [1:0] row_idx,
    input  logic       contact,
    input  logic [3:0] col,
    output logic [3:0] row_pat
);

    always_comb begin
        row_pat = LINES_IDLE;
        if (contact && !col[2'd3 - col_idx]) begin
            row_pat[2'd3 - row_idx] = 1'b0;
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x4 hex keypad contact emulator: plays each accepted code as bounce/hold/gap.
// Define KEYPAD_EMU_BOUNCE_EN to add the contact-chatter phase before HOLD.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 1000000,
    parameter int unsigned GAP_CYCLES    = 1000000,
    parameter int unsigned BOUNCE_CYCLES = 2000,
    parameter int unsigned BOUNCE_PERIOD = 50,
    parameter int unsigned CNT_W         = 24
)
(
    input  logic                           clk,
    input  logic                           rst_n,
    keypad_matrix_emulator_if.slave        key_if,
    input  logic [3:0]                     Col,
    output logic [3:0]                     Row,
    output logic                           pressed,
    output logic                           busy,
    output state_t                         dbg_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    if ((HOLD_CYCLES == 0) || (GAP_CYCLES == 0) || (BOUNCE_CYCLES == 0) ||
        (BOUNCE_PERIOD == 0) || ((64'(HOLD_CYCLES) >> CNT_W) != 0) ||
        ((64'(GAP_CYCLES) >> CNT_W) != 0) || ((64'(BOUNCE_CYCLES) >> CNT_W) != 0)) begin : g_param_check
        $error("keypad_matrix_emulator: phase lengths must be nonzero and fit in CNT_W");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       code_q;
    logic             started;
    logic             key_ready;
    logic             accept;
    logic             phase_done;
    logic             contact;
    key_rc_t          rc;
    logic [3:0]       row_pat;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BOUNCE_PERIOD - 1);
    localparam state_t           FIRST_PHASE = BOUNCE;

    logic [CNT_W-1:0] bnc_cnt;
    logic             bnc_open;

    // Chatter starts closed and flips every BOUNCE_PERIOD cycles inside BOUNCE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bnc_cnt  <= '0;
            bnc_open <= 1'b0;
        end else if (state != BOUNCE) begin
            bnc_cnt  <= '0;
            bnc_open <= 1'b0;
        end else if (bnc_cnt == PERIOD_LAST) begin
            bnc_cnt  <= '0;
            bnc_open <= ~bnc_open;
        end else begin
            bnc_cnt <= bnc_cnt + 1'b1;
        end
    end
`else
    localparam state_t FIRST_PHASE = HOLD;
`endif

    assign accept    = key_if.key_valid && key_ready;
    assign rc        = key_to_rc(code_q);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        phase_done = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = FIRST_PHASE;
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE: begin
                phase_done = (cnt == BOUNCE_LAST);
                if (phase_done) state_nxt = HOLD;
            end
`endif
            HOLD: begin
                phase_done = (cnt == HOLD_LAST);
                if (phase_done) state_nxt = GAP;
            end
            GAP: begin
                phase_done = (cnt == GAP_LAST);
                if (phase_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // key_ready stays low until the first edge after reset release.
    always_comb begin
        key_ready = (state == IDLE) && started;
        busy      = (state != IDLE);
        contact   = 1'b0;
        case (state)
            HOLD:    contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE:  contact = ~bnc_open;
`endif
            default: contact = 1'b0;
        endcase
    end

    assign key_if.key_ready = key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            code_q <= 4'h0;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                code_q <= key_if.key_code;
            end
        end
    end

    keypad_row_drive u_row_drive (
        .col_idx (rc.col),
        .row_idx (rc.row),
        .contact (contact),
        .col     (Col),
        .row_pat (row_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Row     <= LINES_IDLE;
            pressed <= 1'b0;
        end else begin
            Row     <= row_pat;
            pressed <= contact;
        end
    end

endmodule
